// File: rtl/tmds_decoder.sv
// TMDS symbol decoder with a symbol-alignment lock FSM.
//
// Two-stage pipeline: stage 1 registers the raw 10-bit symbol, stage 2
// registers the decoded outputs (2-cycle latency, one symbol per cycle).
// The lock FSM watches the stage-1 symbol for runs of control tokens. While
// searching without success it requests a one-bit deserializer shift.
//
// Ports:
//   i_clk      single clock, rising edge
//   i_rst      synchronous active-high reset
//   i_data     received 10-bit TMDS symbol, bit 0 first on the wire
//   o_de       1 = data symbol, 0 = control symbol
//   o_ctrl     decoded control value, held across data symbols
//   o_data     decoded pixel byte (0 for control symbols)
//   o_locked   symbol alignment achieved
//   o_bitslip  one-cycle request to shift deserializer alignment by one bit
module tmds_decoder #(
  parameter int unsigned LOCK_TOKENS = 8,
  parameter int unsigned SEARCH_LEN  = 2048,
  parameter int unsigned SLIP_WAIT   = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [9:0] i_data,
  output logic       o_de,
  output logic [1:0] o_ctrl,
  output logic [7:0] o_data,
  output logic       o_locked,
  output logic       o_bitslip
);

  // Run counter must hold the saturated value LOCK_TOKENS itself.
  localparam int unsigned RUN_W  = $clog2(LOCK_TOKENS + 1);
  localparam int unsigned CYC_W  = (SEARCH_LEN > 1) ? $clog2(SEARCH_LEN) : 1;
  localparam int unsigned WAIT_W = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_SLIP   = 2'd1,
    ST_WAIT   = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  logic [9:0]        sym_q;
  logic              de_q, de_d;
  logic [1:0]        ctrl_q, ctrl_d;
  logic [7:0]        data_q, data_d;
  logic              locked_q, locked_d;
  logic              bitslip_q, bitslip_d;
  state_t            state_q, state_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic              is_tok;
  logic [1:0]        tok_val;
  logic [7:0]        d;
  logic [7:0]        dec;
  logic [RUN_W-1:0]  run_next;

  // Symbol decode of the stage-1 register.
  always_comb begin
    is_tok  = 1'b1;
    tok_val = 2'b00;
    case (sym_q)
      10'b1101010100: tok_val = 2'b00;
      10'b0010101011: tok_val = 2'b01;
      10'b0101010100: tok_val = 2'b10;
      10'b1010101011: tok_val = 2'b11;
      default:        is_tok  = 1'b0;
    endcase

    d      = sym_q[9] ? ~sym_q[7:0] : sym_q[7:0];
    dec    = '0;
    dec[0] = d[0];
    for (int unsigned k = 1; k < 8; k++) begin
      dec[k] = sym_q[8] ? (d[k] ^ d[k-1]) : ~(d[k] ^ d[k-1]);
    end

    de_d   = ~is_tok;
    ctrl_d = is_tok ? tok_val : ctrl_q;
    data_d = is_tok ? 8'h00 : dec;
  end

  // Lock FSM next-state logic.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    cyc_d   = cyc_q;
    wait_d  = wait_q;

    if (!is_tok)
      run_next = '0;
    else if (run_q == RUN_W'(LOCK_TOKENS))
      run_next = run_q;
    else
      run_next = run_q + 1'b1;

    case (state_q)
      ST_SEARCH: begin
        run_d = run_next;
        // A completed token run wins over a coincident timeout.
        if (run_next == RUN_W'(LOCK_TOKENS)) begin
          state_d = ST_LOCKED;
          cyc_d   = '0;
        end else if (cyc_q == CYC_W'(SEARCH_LEN - 1)) begin
          state_d = ST_SLIP;
          cyc_d   = '0;
          run_d   = '0;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      ST_SLIP: begin
        state_d = ST_WAIT;
        run_d   = '0;
        cyc_d   = '0;
        wait_d  = '0;
      end
      ST_WAIT: begin
        if (wait_q == WAIT_W'(SLIP_WAIT - 1)) begin
          state_d = ST_SEARCH;
          wait_d  = '0;
          run_d   = '0;
          cyc_d   = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_LOCKED: begin
        run_d = run_next;
        if (is_tok) begin
          cyc_d = '0;
        end else if (cyc_q == CYC_W'(SEARCH_LEN - 1)) begin
          state_d = ST_SEARCH;
          cyc_d   = '0;
          run_d   = '0;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_SEARCH;
        run_d   = '0;
        cyc_d   = '0;
        wait_d  = '0;
      end
    endcase

    // Status flags are registered copies of the next state.
    locked_d  = (state_d == ST_LOCKED);
    bitslip_d = (state_d == ST_SLIP);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sym_q     <= '0;
      de_q      <= 1'b0;
      ctrl_q    <= '0;
      data_q    <= '0;
      locked_q  <= 1'b0;
      bitslip_q <= 1'b0;
      state_q   <= ST_SEARCH;
      run_q     <= '0;
      cyc_q     <= '0;
      wait_q    <= '0;
    end else begin
      sym_q     <= i_data;
      de_q      <= de_d;
      ctrl_q    <= ctrl_d;
      data_q    <= data_d;
      locked_q  <= locked_d;
      bitslip_q <= bitslip_d;
      state_q   <= state_d;
      run_q     <= run_d;
      cyc_q     <= cyc_d;
      wait_q    <= wait_d;
    end
  end

  assign o_de      = de_q;
  assign o_ctrl    = ctrl_q;
  assign o_data    = data_q;
  assign o_locked  = locked_q;
  assign o_bitslip = bitslip_q;

endmodule
